// File: rtl/sum_latch_pkg.sv
// Shared types, ASCII constants and helpers for the operand-sum UART sequencer.
package sum_latch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSum,
        StWaitIdle,
        StSend,
        StWaitAck,
        StWaitDone
    } ctrl_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + wide;
        end
        return ASCII_A + wide - 8'd10;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low button conditioner: 2-flop synchroniser, debounce counter and a one-cycle
// press pulse. A new press is only accepted after the button has been stably released.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pressed_q, pressed_d;
    logic            press_q, press_d;
    logic            btn_low;

    assign btn_low = ~sync_q[1];
    assign press_o = press_q;

    // cnt_q counts consecutive cycles in which the synchronised level differs from the
    // accepted level; the accepted level flips once that run reaches DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        if (btn_low != pressed_q) begin
            if (cnt_q == CntLast) begin
                pressed_d = btn_low;
                press_d   = btn_low;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_n_i};
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
        end
    end

endmodule

// File: rtl/sum_latch_tx_ctrl.sv
// Latches two debounced operands, sums them and sends the result over a UART handshake.
// Define ASCII_RESULT_EN to send the sum as two uppercase hex digits plus LF.
module sum_latch_tx_ctrl
    import sum_latch_pkg::*;
#(
    parameter int unsigned DATA_W          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BUSY_TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [DATA_W:0]   result,
    output logic              result_valid,
    output logic              a_held,
    output logic              b_held,
    output logic              tx_error
);

    localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              a_held_q, a_held_d;
    logic              b_held_q, b_held_d;
    logic [DATA_W:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_error_q, tx_error_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              press_a, press_b;
    logic              byte_rst, byte_inc;
    logic [7:0]        cur_byte;
    logic              last_byte;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk    (clk),
        .reset  (reset),
        .btn_n_i(save_a_n),
        .press_o(press_a)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk    (clk),
        .reset  (reset),
        .btn_n_i(save_b_n),
        .press_o(press_b)
    );

`ifdef ASCII_RESULT_EN
    localparam logic [1:0] LastByte = 2'd2;

    logic [1:0] byte_q;
    logic [3:0] hi_nib;

    assign hi_nib    = 4'(result_q >> 4);
    assign last_byte = (byte_q == LastByte);

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = nibble_to_ascii(hi_nib);
            2'd1:    cur_byte = nibble_to_ascii(result_q[3:0]);
            default: cur_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q <= '0;
        end else if (byte_rst) begin
            byte_q <= '0;
        end else if (byte_inc) begin
            byte_q <= byte_q + 2'd1;
        end
    end
`else
    logic unused_byte_ctrl;

    assign unused_byte_ctrl = byte_rst ^ byte_inc;
    assign cur_byte         = 8'(result_q);
    assign last_byte        = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        a_held_d       = a_held_q;
        b_held_d       = b_held_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        tx_data_d      = tx_data_q;
        tx_error_d     = tx_error_q;
        tmo_d          = tmo_q;
        tx_start       = 1'b0;
        byte_rst       = 1'b0;
        byte_inc       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (press_a) begin
                    a_d      = data_input;
                    a_held_d = 1'b1;
                end
                if (press_b) begin
                    b_d      = data_input;
                    b_held_d = 1'b1;
                end
                // Look at the next-state flags so the final press moves on this same edge.
                if (a_held_d && b_held_d) begin
                    state_d = StSum;
                end
            end
            StSum: begin
                result_d       = {1'b0, a_q} + {1'b0, b_q};
                result_valid_d = 1'b1;
                byte_rst       = 1'b1;
                state_d        = StWaitIdle;
            end
            StWaitIdle: begin
                if (!tx_busy) begin
                    tx_data_d = cur_byte;
                    state_d   = StSend;
                end
            end
            StSend: begin
                tx_start = 1'b1;
                tmo_d    = '0;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    tx_error_d     = 1'b1;
                    a_d            = '0;
                    b_d            = '0;
                    a_held_d       = 1'b0;
                    b_held_d       = 1'b0;
                    result_valid_d = 1'b0;
                    byte_rst       = 1'b1;
                    state_d        = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (!last_byte) begin
                        byte_inc = 1'b1;
                        state_d  = StWaitIdle;
                    end else begin
                        a_d            = '0;
                        b_d            = '0;
                        a_held_d       = 1'b0;
                        b_held_d       = 1'b0;
                        result_valid_d = 1'b0;
                        byte_rst       = 1'b1;
                        state_d        = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            a_q            <= '0;
            b_q            <= '0;
            a_held_q       <= 1'b0;
            b_held_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            tx_data_q      <= '0;
            tx_error_q     <= 1'b0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            a_held_q       <= a_held_d;
            b_held_q       <= b_held_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            tx_data_q      <= tx_data_d;
            tx_error_q     <= tx_error_d;
            tmo_q          <= tmo_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign a_held       = a_held_q;
    assign b_held       = b_held_q;
    assign tx_error     = tx_error_q;

endmodule

// File: tb/tb_sum_latch_tx_ctrl.sv
// Scoreboard bench for sum_latch_tx_ctrl: stimulus pushes expected sums and bytes, monitors
// pop and compare on result_valid rising and on each tx_start.
module tb_sum_latch_tx_ctrl;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          save_a_n;
    logic          save_b_n;
    logic [DW-1:0] data_input;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [DW:0]   result;
    logic          result_valid;
    logic          a_held;
    logic          b_held;
    logic          tx_error;

    int          n_cmp = 0;
    int          n_err = 0;
    int          tx_count = 0;
    bit          uart_dead = 1'b0;
    logic [7:0]  exp_tx_q[$];
    logic [DW:0] exp_res_q[$];

    sum_latch_tx_ctrl #(
        .DATA_W         (DW),
        .DEBOUNCE_CYCLES(4),
        .BUSY_TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .save_a_n    (save_a_n),
        .save_b_n    (save_b_n),
        .data_input  (data_input),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .result      (result),
        .result_valid(result_valid),
        .a_held      (a_held),
        .b_held      (b_held),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // nbytes = 0 queues the whole message, otherwise only the first nbytes of it.
    task automatic expect_send(input logic [DW:0] res, input int nbytes);
        logic [7:0] b [3];
        int         full;
`ifdef ASCII_RESULT_EN
        b[0] = hex_ascii({2'b00, res[5:4]});
        b[1] = hex_ascii(res[3:0]);
        b[2] = 8'h0A;
        full = 3;
`else
        b[0] = {2'b00, res};
        b[1] = 8'h00;
        b[2] = 8'h00;
        full = 1;
`endif
        if (nbytes != 0 && nbytes < full) full = nbytes;
        exp_res_q.push_back(res);
        for (int i = 0; i < full; i++) exp_tx_q.push_back(b[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input bit is_b, input logic [DW-1:0] d, input int lo, input int hi);
        data_input = d;
        if (is_b) save_b_n = 1'b0;
        else      save_a_n = 1'b0;
        tick(lo);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        if (hi > 0) tick(hi);
    endtask

    task automatic wait_tx(input int c0);
        int i;
        for (i = 0; i < 200; i++) begin
            if (tx_count > c0) break;
            tick(1);
        end
        if (i == 200) check("wait_tx_start_timeout", 32'(tx_count), 32'(c0 + 1));
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            if (!result_valid && !tx_busy) break;
            tick(1);
        end
        if (i == 400) check("wait_idle_timeout", 32'(result_valid), 0);
        tick(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_result_valid"}, 32'(result_valid), 0);
        check({tag, "_a_held"}, 32'(a_held), 0);
        check({tag, "_b_held"}, 32'(b_held), 0);
        check({tag, "_tx_error"}, 32'(tx_error), 0);
    endtask

    // UART model: busy rises the cycle after tx_start and stays up for 10 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !uart_dead && !reset) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every presented byte and every fresh result.
    initial begin
        logic       rv_prev;
        logic [7:0] eb;
        logic [DW:0] er;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rv_prev = 1'b0;
            end else begin
                if (tx_start) begin
                    tx_count++;
                    if (exp_tx_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_unexpected: got byte %0h, none expected (t=%0t)",
                                 tx_data, $time);
                    end else begin
                        eb = exp_tx_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(eb));
                    end
                end
                if (result_valid && !rv_prev) begin
                    if (exp_res_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL result_unexpected: got %0d, none expected (t=%0t)",
                                 result, $time);
                    end else begin
                        er = exp_res_q.pop_front();
                        check("result", 32'(result), 32'(er));
                    end
                end
                rv_prev = result_valid;
            end
        end
    end

    initial begin
        int c0;
        reset      = 1'b1;
        save_a_n   = 1'b1;
        save_b_n   = 1'b1;
        data_input = '0;
        tick(3);
        check_zero("reset");
        reset = 1'b0;
        tick(2);

        // 1: basic sum 3 + 4
        expect_send(6'd7, 0);
        press_btn(1'b0, 5'd3, 8, 8);
        check("t1_a_held", 32'(a_held), 1);
        check("t1_b_held_before", 32'(b_held), 0);
        press_btn(1'b1, 5'd4, 8, 8);
        wait_idle();
        check("t1_a_cleared", 32'(a_held), 0);
        check("t1_b_cleared", 32'(b_held), 0);
        check("t1_result_holds", 32'(result), 7);

        // 2: maximum operands 31 + 31
        expect_send(6'd62, 0);
        press_btn(1'b0, 5'd31, 8, 8);
        press_btn(1'b1, 5'd31, 8, 8);
        wait_idle();
        check("t2_result_holds", 32'(result), 62);

        // 3: re-press of A overwrites its value
        expect_send(6'd3, 0);
        press_btn(1'b0, 5'd9, 8, 8);
        check("t3_a_held", 32'(a_held), 1);
        press_btn(1'b0, 5'd2, 8, 8);
        check("t3_b_not_held", 32'(b_held), 0);
        press_btn(1'b1, 5'd1, 8, 8);
        wait_idle();

        // 4: short glitch rejected; press during send dropped
        save_a_n = 1'b0;
        tick(2);
        save_a_n = 1'b1;
        tick(10);
        check("t4_glitch_a_held", 32'(a_held), 0);
        expect_send(6'd3, 0);
        press_btn(1'b0, 5'd1, 8, 8);
        c0 = tx_count;
        press_btn(1'b1, 5'd2, 8, 0);
        wait_tx(c0);
        press_btn(1'b0, 5'd9, 6, 8);
        wait_idle();
        tick(4);
        check("t4_dropped_a_held", 32'(a_held), 0);
        check("t4_dropped_b_held", 32'(b_held), 0);

        // 5: UART never acknowledges
        uart_dead = 1'b1;
        expect_send(6'd30, 1);
        press_btn(1'b0, 5'd10, 8, 8);
        c0 = tx_count;
        press_btn(1'b1, 5'd20, 8, 0);
        wait_tx(c0);
        tick(15);
        check("t5_error_not_yet", 32'(tx_error), 0);
        tick(1);
        check("t5_tx_error", 32'(tx_error), 1);
        check("t5_a_held", 32'(a_held), 0);
        check("t5_b_held", 32'(b_held), 0);
        check("t5_result_valid", 32'(result_valid), 0);
        uart_dead = 1'b0;
        tick(5);
        check("t5_error_sticky", 32'(tx_error), 1);

        // 6: reset in the middle of a send, then a clean send
        expect_send(6'd11, 1);
        press_btn(1'b0, 5'd5, 8, 8);
        c0 = tx_count;
        press_btn(1'b1, 5'd6, 8, 0);
        wait_tx(c0);
        tick(3);
        reset = 1'b1;
        #1;
        check_zero("t6_reset");
        tick(2);
        reset = 1'b0;
        tick(15);
        expect_send(6'd2, 0);
        press_btn(1'b0, 5'd1, 8, 8);
        press_btn(1'b1, 5'd1, 8, 8);
        wait_idle();
        check("t6_result", 32'(result), 2);

        tick(20);
        check("tx_queue_drained", 32'(exp_tx_q.size()), 0);
        check("result_queue_drained", 32'(exp_res_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
